// File: rtl/jk_register_counter.sv
`default_nettype none
// ============================================================================
//  Module   : jk_register_counter
//  Purpose  : WIDTH-bit register in which every bit behaves as a JK flip-flop,
//             with modulo up/down count and parallel-load modes. Provides a
//             registered wrap pulse and a combinational terminal-count flag
//             for cascading.
//  Revision : 1.0 - initial release
// ============================================================================
module jk_register_counter #(
    parameter int              WIDTH     = 8,
    parameter logic [WIDTH-1:0] MAX_COUNT = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_b,
    output logic             tc,
    output logic             wrap
);

    localparam logic [1:0]       c_MODE_JK   = 2'b00;
    localparam logic [1:0]       c_MODE_UP   = 2'b01;
    localparam logic [1:0]       c_MODE_DOWN = 2'b10;
    localparam logic [1:0]       c_MODE_LOAD = 2'b11;
    localparam logic [WIDTH-1:0] c_ONE       = WIDTH'(1);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic             wrap_q;
    logic             wrap_d;

    // Next-state selection: hold when disabled, otherwise apply the mode.
    always_comb begin
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
        if (en) begin
            case (mode)
                // Per bit: J sets, K clears, both toggle, neither holds.
                c_MODE_JK: cnt_d = (j & ~cnt_q) | (~k & cnt_q);
                c_MODE_UP: begin
                    // Values at or above MAX_COUNT (e.g. after a load) wrap to 0.
                    if (cnt_q >= MAX_COUNT) begin
                        cnt_d  = '0;
                        wrap_d = 1'b1;
                    end else begin
                        cnt_d  = cnt_q + c_ONE;
                    end
                end
                c_MODE_DOWN: begin
                    // Out-of-range values simply decrement; only 0 wraps.
                    if (cnt_q == '0) begin
                        cnt_d  = MAX_COUNT;
                        wrap_d = 1'b1;
                    end else begin
                        cnt_d  = cnt_q - c_ONE;
                    end
                end
                c_MODE_LOAD: cnt_d = d;
                default:     cnt_d = cnt_q;
            endcase
        end
    end

    // State register with synchronous reset taking priority over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wrap_q <= wrap_d;
        end
    end

    // Terminal count predicts a wrap on the next enabled edge, regardless of en.
    always_comb begin
        tc = ((mode == c_MODE_UP) && (cnt_q >= MAX_COUNT)) ||
             ((mode == c_MODE_DOWN) && (cnt_q == '0));
    end

    assign q    = cnt_q;
    assign q_b  = ~cnt_q;
    assign wrap = wrap_q;

endmodule
`default_nettype wire
